// File: rtl/mem_responder.sv
// Word-addressed memory that answers the multicycle CPU's read/write handshake.
// It latches each request, waits LATENCY edges, performs the access and pulses mem_resp.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy,
  output logic        proto_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]           r_state;
  logic [3:0]           r_cnt;
  logic                 r_wr;
  logic [ADDR_BITS-1:0] r_idx;
  logic [31:0]          r_wdata;
  logic [3:0]           r_be;
  logic [31:0]          r_rdata;
  logic                 r_resp;
  logic                 r_err;
  logic [31:0]          r_mem [0:(1<<ADDR_BITS)-1];

  logic                 w_fire;
  logic                 w_req_one;
  logic                 w_conflict;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_unused_addr;

  assign w_fire        = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_req_one     = mem_read ^ mem_write;
  assign w_conflict    = mem_read & mem_write;
  assign w_idx         = mem_address[ADDR_BITS+1:2];
  // Bits outside the word index alias by design.
  assign w_unused_addr = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_resp <= w_fire;
      case (r_state)
        S_IDLE: begin
          if (w_conflict) begin
            r_err <= 1'b1;
          end else if (w_req_one) begin
            r_wr    <= mem_write;
            r_idx   <= w_idx;
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
            if (!r_wr) r_rdata <= r_mem[r_idx];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; the rst gate discards a write that would land on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && r_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = r_resp;
  assign busy      = (r_state != S_IDLE);
  assign proto_err = r_err;

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable word-addressed memory that serves the responder end of the multicycle CPU's memory handshake. The datapath drives `mem_address`/`mem_wdata` and control raises `mem_read` or `mem_write`; this block latches the request, waits a programmable latency, then performs the access and pulses `mem_resp` for one cycle. It replaces the behavioral memory in the CPU top-level for simulation and FPGA builds.

## Interface
- `ADDR_BITS`, default 8: word-index width; the array holds 2^ADDR_BITS 32-bit words.
- `LATENCY`, default 2, legal range 1..15: number of wait edges between request acceptance and the response.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mem_read` input 1: read request level, held by the initiator until `mem_resp`.
- `mem_write` input 1: write request level, held by the initiator until `mem_resp`.
- `mem_byte_enable` input 4: write lane mask; bit i enables byte i (`[8i+7:8i]`).
- `mem_address` input 32: byte address; bits `[ADDR_BITS+1:2]` select the word; all other bits are ignored, so higher addresses alias.
- `mem_wdata` input 32: write data.
- `mem_rdata` output 32: read data, registered.
- `mem_resp` output 1: one-cycle completion pulse, registered.
- `busy` output 1: high while a transaction is outstanding.
- `proto_err` output 1: sticky flag, set when `mem_read` and `mem_write` are both high in IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - If exactly one of `mem_read`/`mem_write` is high, latch the operation, word index, `mem_wdata` and `mem_byte_enable`, load `cnt = LATENCY-1`, and go to WAIT.
  - If both are high, set `proto_err`, accept nothing and stay in IDLE.
  - If neither is high, stay in IDLE.
- **WAIT**
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, go to RESP and perform the access using only latched values:
    - Write: update only the enabled lanes of `array[idx]`. A mask of 0 changes nothing but still produces a response. `mem_rdata` is unchanged.
    - Read: `mem_rdata <= array[idx]`.
  - Request inputs are ignored. Dropping or changing them mid-transaction neither aborts nor alters the transaction.
- **RESP**
  - `mem_resp = 1`; go to IDLE unconditionally.
  - Requests are not sampled in this state. A request still high afterwards is treated as a new request in IDLE.
- `busy = 1` in WAIT and RESP, 0 in IDLE.
- `mem_rdata` holds its value until the next read completes. Writes never disturb it.
- A read after a write to the same word, in a later transaction, returns the merged new data.
- Reset clears all state and outputs but leaves array contents untouched. Initial array contents are undefined.

## Timing
- Reset values: IDLE, `mem_resp=0`, `busy=0`, `mem_rdata=0`, `proto_err=0`, `cnt=0`.
- **Reset mid-transaction:** the next state is IDLE, any pending write is discarded with no array update, and no `mem_resp` is produced. `rst` has priority over every other condition.
- **Latency:** a request first sampled at edge k is handled as follows.
  - It enters WAIT at edge k.
  - It reaches RESP at edge k+LATENCY; the array write or `mem_rdata` load happens at that same edge.
  - `mem_resp` is high for exactly the cycle between edges k+LATENCY and k+LATENCY+1.
- With `LATENCY=1`, `mem_resp` is high the cycle after the acceptance edge's successor.
- **Back-to-back:** the earliest next acceptance is edge k+LATENCY+2. Throughput is one transaction per LATENCY+2 cycles.
- `mem_rdata` is valid in the same cycle `mem_resp` is high. The initiator samples it at edge k+LATENCY+1.
- `proto_err` is set at the edge sampling the conflict and cleared only by `rst`.

## Test plan
- **Full write then read** (LATENCY=2): write addr 0x0000_0010, data 0xDEAD_BEEF, mask 0xF. Then read 0x10. Expected:
  - Each `mem_resp` is a single pulse exactly 2 edges after its acceptance edge.
  - Read `mem_rdata` = 0xDEAD_BEEF.
  - `busy` is high for 3 cycles per transaction.
- **Byte lanes:** preload word 0x20 = 0x1122_3344. Write 0xAABB_CCDD with mask 0b0101. Read 0x20 -> 0x11BB_33DD. A mask-0 write to 0x20 still pulses `mem_resp`; a subsequent read still returns 0x11BB_33DD.
- **Aliasing and misalignment** (ADDR_BITS=8): write 0x5555_AAAA at 0x0000_0004. Read 0x0000_0406 -> 0x5555_AAAA. Read 0x0000_0008 -> a different word, not altered by the write.
- **Request drop and held request:**
  - Start a write, then deassert `mem_write` on the following cycle. `mem_resp` still pulses on schedule and the data is written.
  - Hold `mem_read` continuously. Responses repeat every LATENCY+2 cycles.
- **Reset mid-write:** assert `rst` one cycle after accepting a write to 0x30 (old value 0x0000_0001).
  - No `mem_resp`; `busy=0` next cycle; `mem_rdata=0`.
  - A later read of 0x30 returns 0x0000_0001.
- **Protocol error and LATENCY sweep:**
  - Assert `mem_read` and `mem_write` together. `proto_err` goes to 1, `busy` stays 0, and no response is produced.
  - `proto_err` stays high after the inputs drop and clears only on `rst`.
  - Repeat the first scenario with LATENCY=1 and LATENCY=15, checking the edge counts.
